// File: rtl/regfile_pkg.sv
// regfile_pkg: widths and types shared between the register file and its writeback arbiter
package regfile_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] dst;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant whose pointer advances only on an accepted request
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1,
  output logic gnt
);
  logic rr_last;
  assign gnt    = (valid0 && valid1) ? !rr_last : valid1;
  assign ready0 = en && valid0 && !gnt;
  assign ready1 = en && valid1 && gnt;
  // remember the last requester that actually transferred; reset favours req0 on first contention
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_last <= 1'b1;
    else if (ready0 || ready1) rr_last <= gnt;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between ALU and load writeback
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ADDR_W-1:0]    req0_reg,
  input  logic [DATA_W-1:0]    req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ADDR_W-1:0]    req1_reg,
  input  logic [DATA_W-1:0]    req1_data,
  input  logic                 rf_stall,
  output logic                 rf_write,
  output logic [ADDR_W-1:0]    rf_write_reg,
  output logic [DATA_W-1:0]    rf_write_data,
  output logic                 grant_id,
  output logic [2**ADDR_W-1:0] busy_mask,
  output logic [CNT_W-1:0]     conflict_count
);
  localparam logic [2**ADDR_W-1:0] ONE = 1;
  logic out_valid, gnt, xfer, nonzero;
  rr_arbiter2 u_rr (
    .clk(clk), .rst_n(rst_n), .en(!rf_stall),
    .valid0(req0_valid), .valid1(req1_valid),
    .ready0(req0_ready), .ready1(req1_ready), .gnt(gnt)
  );
  assign xfer      = req0_ready || req1_ready;
  assign nonzero   = rf_write_reg != ADDR_W'(REG_ZERO);
  assign rf_write  = out_valid && !rf_stall && nonzero;
  assign busy_mask = (out_valid && nonzero) ? ONE << rf_write_reg : '0;
  // output stage: a stall freezes the held write; otherwise it retires and a new grant may load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid     <= 1'b0;
      rf_write_reg  <= '0;
      rf_write_data <= '0;
      grant_id      <= 1'b0;
    end else if (!rf_stall) begin
      out_valid <= xfer;
      if (xfer) begin
        rf_write_reg  <= gnt ? req1_reg : req0_reg;
        rf_write_data <= gnt ? req1_data : req0_data;
        grant_id      <= gnt;
      end
    end
  // count contended unstalled cycles, saturating at all ones
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) conflict_count <= '0;
    else if (req0_valid && req1_valid && !rf_stall && conflict_count != '1)
      conflict_count <= conflict_count + 1'b1;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, stall, reg0, async reset and saturation
module tb_regfile_write_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        req0_valid = 0, req1_valid = 0, rf_stall = 0;
  logic        req0_ready, req1_ready, rf_write, grant_id;
  logic [4:0]  req0_reg = 0, req1_reg = 0, rf_write_reg;
  logic [31:0] req0_data = 0, req1_data = 0, rf_write_data, busy_mask;
  logic [3:0]  conflict_count;
  int checks = 0, passes = 0;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
    .rf_stall(rf_stall), .rf_write(rf_write), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .grant_id(grant_id), .busy_mask(busy_mask),
    .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick; tick;
    chk("rst_rf_write", rf_write, 0);
    chk("rst_reg", rf_write_reg, 0);
    chk("rst_data", rf_write_data, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_count", conflict_count, 0);
    rst_n = 1;
    // single req0 write
    req0_valid = 1; req0_reg = 5; req0_data = 32'h1234;
    #1;
    chk("r0_ready0", req0_ready, 1);
    chk("r0_ready1", req1_ready, 0);
    tick;
    req0_valid = 0;
    chk("r0_write", rf_write, 1);
    chk("r0_reg", rf_write_reg, 5);
    chk("r0_data", rf_write_data, 32'h1234);
    chk("r0_busy", busy_mask, 32'h20);
    chk("r0_grant", grant_id, 0);
    tick;
    chk("r0_retire", rf_write, 0);
    // contention: req0 took the last slot, so req1 wins first
    req0_valid = 1; req0_reg = 3; req0_data = 32'hA;
    req1_valid = 1; req1_reg = 4; req1_data = 32'hB;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_ready0", req0_ready, (k % 2) == 1);
      chk("cont_ready1", req1_ready, (k % 2) == 0);
      tick;
      chk("cont_grant", grant_id, (k % 2) == 0);
      chk("cont_reg", rf_write_reg, (k % 2) == 0 ? 4 : 3);
      chk("cont_data", rf_write_data, (k % 2) == 0 ? 32'hB : 32'hA);
      chk("cont_count", conflict_count, k + 1);
    end
    req0_valid = 0; req1_valid = 0;
    // reg 0 write consumes a slot silently
    req1_valid = 1; req1_reg = 0; req1_data = 32'hFFFF;
    #1;
    chk("z_ready1", req1_ready, 1);
    tick;
    req1_valid = 0;
    chk("z_write", rf_write, 0);
    chk("z_busy", busy_mask, 0);
    chk("z_grant", grant_id, 1);
    req0_valid = 1; req0_reg = 9; req0_data = 32'h55;
    #1;
    chk("z_next_ready0", req0_ready, 1);
    tick;
    req0_valid = 0;
    chk("z_next_write", rf_write, 1);
    chk("z_next_reg", rf_write_reg, 9);
    chk("z_next_busy", busy_mask, 32'h200);
    // stall holds reg 7 for three cycles
    req0_valid = 1; req0_reg = 7; req0_data = 32'h77;
    tick;
    rf_stall = 1; req0_reg = 8; req0_data = 32'h88;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_ready0", req0_ready, 0);
      chk("st_ready1", req1_ready, 0);
      chk("st_write", rf_write, 0);
      chk("st_busy", busy_mask, 32'h80);
      tick;
      chk("st_hold_reg", rf_write_reg, 7);
    end
    rf_stall = 0;
    #1;
    chk("rel_write", rf_write, 1);
    chk("rel_reg", rf_write_reg, 7);
    chk("rel_data", rf_write_data, 32'h77);
    chk("rel_ready0", req0_ready, 1);
    tick;
    req0_valid = 0;
    chk("rel_next_write", rf_write, 1);
    chk("rel_next_reg", rf_write_reg, 8);
    chk("rel_next_data", rf_write_data, 32'h88);
    chk("rel_count", conflict_count, 4);
    // asynchronous reset between edges drops the in-flight write
    req0_valid = 1; req0_reg = 10; req0_data = 32'hAA;
    tick;
    req0_valid = 0;
    chk("ar_write_pre", rf_write, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_write", rf_write, 0);
    chk("ar_busy", busy_mask, 0);
    chk("ar_count", conflict_count, 0);
    #1 rst_n = 1;
    req0_valid = 1; req0_reg = 1; req0_data = 32'h1;
    req1_valid = 1; req1_reg = 2; req1_data = 32'h2;
    #1;
    chk("ar_first_ready0", req0_ready, 1);
    chk("ar_first_ready1", req1_ready, 0);
    // saturation of the 4-bit conflict counter
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (k == 14) chk("sat_14", conflict_count, 14);
      if (k == 15) chk("sat_15", conflict_count, 15);
    end
    chk("sat_hold", conflict_count, 15);
    req0_valid = 0; req1_valid = 0;
    tick;
    chk("sat_idle", conflict_count, 15);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
